// File: rtl/dpb_gen_pkg.sv
// Shared encodings for the dpb_gen dual-port RAM model: write/read modes and
// the power-on clear FSM state type.
package dpb_gen_pkg;

    localparam int WM_NORMAL            = 0;
    localparam int WM_WRITE_THROUGH     = 1;
    localparam int WM_READ_BEFORE_WRITE = 2;

    localparam int RM_BYPASS = 0;
    localparam int RM_PIPE   = 1;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } dpb_gen_state_t;

endpackage

// File: rtl/dpb_gen_if.sv
// Port A / port B bus of the dpb_gen RAM; the RAM is the slave, the user the master.
interface dpb_gen_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11
);
    logic              CEA, CEB;
    logic              OCEA, OCEB;
    logic              WREA, WREB;
    logic [ADDR_W-1:0] ADA, ADB;
    logic [DATA_W-1:0] DIA, DIB;
    logic [DATA_W-1:0] DOA, DOB;
    logic              INIT_BUSY;
    logic              COLLISION;

    modport master (
        output CEA, CEB, OCEA, OCEB, WREA, WREB, ADA, ADB, DIA, DIB,
        input  DOA, DOB, INIT_BUSY, COLLISION
    );

    modport slave (
        input  CEA, CEB, OCEA, OCEB, WREA, WREB, ADA, ADB, DIA, DIB,
        output DOA, DOB, INIT_BUSY, COLLISION
    );
endinterface

// File: rtl/dpb_gen_port.sv
// One read/write port of dpb_gen: write-mode data-path mux, optional pipeline
// stage and the DO output register.
module dpb_gen_port
    import dpb_gen_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int READ_MODE  = RM_BYPASS,
    parameter int WRITE_MODE = WM_NORMAL
) (
    input  logic              clka_i,
    input  logic              resetb_i,
    input  logic              active_i,
    input  logic              ce_i,
    input  logic              oce_i,
    input  logic              we_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] dout_o
);

    logic              upd;
    logic [DATA_W-1:0] path;
    logic [DATA_W-1:0] stage_q;
    logic [DATA_W-1:0] dout_q;

    // rdata_i is the pre-write array contents, which is exactly what
    // read-before-write and a collided reader must return.
    always_comb begin
        upd  = 1'b0;
        path = rdata_i;
        if (active_i && ce_i) begin
            if (!we_i) begin
                upd = 1'b1;
            end else if (WRITE_MODE == WM_WRITE_THROUGH) begin
                upd  = 1'b1;
                path = wdata_i;
            end else if (WRITE_MODE == WM_READ_BEFORE_WRITE) begin
                upd = 1'b1;
            end
        end
    end

    always_ff @(posedge clka_i) begin
        if (resetb_i) begin
            stage_q <= '0;
            dout_q  <= '0;
        end else if (READ_MODE == RM_PIPE) begin
            if (upd)
                stage_q <= path;
            if (active_i && oce_i)
                dout_q <= stage_q;
        end else if (upd && oce_i) begin
            dout_q <= path;
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/dpb_gen.sv
// Parametrised true-dual-port RAM model with power-on clear sweep and A-wins
// collision resolution; define DPB_GEN_COLLISION_EN to build the COLLISION pulse.
module dpb_gen
    import dpb_gen_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 11,
    parameter int READ_MODE    = RM_BYPASS,
    parameter int WRITE_MODE_A = WM_NORMAL,
    parameter int WRITE_MODE_B = WM_NORMAL,
    parameter int INIT_CLEAR   = 1
) (
    input  logic     CLKA,
    input  logic     RESETB,
    dpb_gen_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    dpb_gen_state_t    state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              run;
    logic [DATA_W-1:0] rd_a, rd_b;

    always_ff @(posedge CLKA) begin
        if (RESETB) begin
            state_q   <= ST_RST;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_RST: begin
                clr_cnt_d = '0;
                state_d   = (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;
            end
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (&clr_cnt_q)
                    state_d = ST_RUN;
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_RST;
        endcase
    end

    assign run           = (state_q == ST_RUN);
    assign bus.INIT_BUSY = !run;
    assign rd_a          = mem_q[bus.ADA];
    assign rd_b          = mem_q[bus.ADB];

    // Port A's write is issued last so it wins a same-address double write.
    always_ff @(posedge CLKA) begin
        if (!RESETB) begin
            if (state_q == ST_CLEAR) begin
                mem_q[clr_cnt_q] <= '0;
            end else if (run) begin
                if (bus.CEB && bus.WREB)
                    mem_q[bus.ADB] <= bus.DIB;
                if (bus.CEA && bus.WREA)
                    mem_q[bus.ADA] <= bus.DIA;
            end
        end
    end

`ifdef DPB_GEN_COLLISION_EN
    logic coll_q;

    always_ff @(posedge CLKA) begin
        if (RESETB)
            coll_q <= 1'b0;
        else
            coll_q <= run && bus.CEA && bus.CEB && (bus.ADA == bus.ADB) &&
                      (bus.WREA || bus.WREB);
    end

    assign bus.COLLISION = coll_q;
`else
    assign bus.COLLISION = 1'b0;
`endif

    dpb_gen_port #(
        .DATA_W     (DATA_W),
        .READ_MODE  (READ_MODE),
        .WRITE_MODE (WRITE_MODE_A)
    ) u_port_a (
        .clka_i   (CLKA),
        .resetb_i (RESETB),
        .active_i (run),
        .ce_i     (bus.CEA),
        .oce_i    (bus.OCEA),
        .we_i     (bus.WREA),
        .wdata_i  (bus.DIA),
        .rdata_i  (rd_a),
        .dout_o   (bus.DOA)
    );

    dpb_gen_port #(
        .DATA_W     (DATA_W),
        .READ_MODE  (READ_MODE),
        .WRITE_MODE (WRITE_MODE_B)
    ) u_port_b (
        .clka_i   (CLKA),
        .resetb_i (RESETB),
        .active_i (run),
        .ce_i     (bus.CEB),
        .oce_i    (bus.OCEB),
        .we_i     (bus.WREB),
        .wdata_i  (bus.DIB),
        .rdata_i  (rd_b),
        .dout_o   (bus.DOB)
    );

endmodule

// File: tb/tb_dpb_gen.sv
// Bench for dpb_gen: two instances (bypass WT/RBW, pipelined normal/normal) share
// one stimulus stream and are compared against an array-based reference model.
module tb_dpb_gen;
    import dpb_gen_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
`ifdef DPB_GEN_COLLISION_EN
    localparam logic COLL_EXP = 1'b1;
`else
    localparam logic COLL_EXP = 1'b0;
`endif

    logic CLKA   = 1'b0;
    logic RESETB = 1'b1;
    always #5 CLKA = ~CLKA;

    logic          ceA = 1'b0, ceB = 1'b0, oceA = 1'b0, oceB = 1'b0;
    logic          weA = 1'b0, weB = 1'b0;
    logic [AW-1:0] adA = '0, adB = '0;
    logic [DW-1:0] diA = '0, diB = '0;

    dpb_gen_if #(.DATA_W(DW), .ADDR_W(AW)) busP ();
    dpb_gen_if #(.DATA_W(DW), .ADDR_W(AW)) busQ ();

    assign busP.CEA = ceA;   assign busQ.CEA = ceA;
    assign busP.CEB = ceB;   assign busQ.CEB = ceB;
    assign busP.OCEA = oceA; assign busQ.OCEA = oceA;
    assign busP.OCEB = oceB; assign busQ.OCEB = oceB;
    assign busP.WREA = weA;  assign busQ.WREA = weA;
    assign busP.WREB = weB;  assign busQ.WREB = weB;
    assign busP.ADA = adA;   assign busQ.ADA = adA;
    assign busP.ADB = adB;   assign busQ.ADB = adB;
    assign busP.DIA = diA;   assign busQ.DIA = diA;
    assign busP.DIB = diB;   assign busQ.DIB = diB;

    dpb_gen #(
        .DATA_W(DW), .ADDR_W(AW), .READ_MODE(RM_BYPASS),
        .WRITE_MODE_A(WM_WRITE_THROUGH), .WRITE_MODE_B(WM_READ_BEFORE_WRITE),
        .INIT_CLEAR(1)
    ) dutP (.CLKA(CLKA), .RESETB(RESETB), .bus(busP.slave));

    dpb_gen #(
        .DATA_W(DW), .ADDR_W(AW), .READ_MODE(RM_PIPE),
        .WRITE_MODE_A(WM_NORMAL), .WRITE_MODE_B(WM_NORMAL),
        .INIT_CLEAR(1)
    ) dutQ (.CLKA(CLKA), .RESETB(RESETB), .bus(busQ.slave));

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] refMem [DEPTH];
    logic [DW-1:0] expDo  [2][2];
    logic [DW-1:0] stage  [2][2];
    logic          expColl;

    function automatic int wmOf(input int d, input int p);
        if (d == 0) return (p == 0) ? WM_WRITE_THROUGH : WM_READ_BEFORE_WRITE;
        return WM_NORMAL;
    endfunction

    function automatic int rmOf(input int d);
        return (d == 0) ? RM_BYPASS : RM_PIPE;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock edge of the RAM as described behaviourally: reads see the
    // contents before this edge, A's write lands after B's.
    task automatic modelEdge();
        logic [DW-1:0] snap [DEPTH];
        logic          ce, we, oce, upd;
        logic [AW-1:0] ad;
        logic [DW-1:0] di, val;
        snap = refMem;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                ce  = (p == 0) ? ceA  : ceB;
                we  = (p == 0) ? weA  : weB;
                oce = (p == 0) ? oceA : oceB;
                ad  = (p == 0) ? adA  : adB;
                di  = (p == 0) ? diA  : diB;
                upd = 1'b0;
                val = '0;
                if (ce) begin
                    if (!we) begin
                        upd = 1'b1; val = snap[ad];
                    end else if (wmOf(d, p) == WM_WRITE_THROUGH) begin
                        upd = 1'b1; val = di;
                    end else if (wmOf(d, p) == WM_READ_BEFORE_WRITE) begin
                        upd = 1'b1; val = snap[ad];
                    end
                end
                if (rmOf(d) == RM_BYPASS) begin
                    if (upd && oce) expDo[d][p] = val;
                end else begin
                    if (oce) expDo[d][p] = stage[d][p];
                    if (upd) stage[d][p] = val;
                end
            end
        end
        if (ceB && weB) refMem[adB] = diB;
        if (ceA && weA) refMem[adA] = diA;
        expColl = ceA && ceB && (adA == adB) && (weA || weB) && COLL_EXP;
`ifdef DPB_GEN_COLLISION_EN
        if (ceA && ceB && (adA == adB) && (weA || weB))
            $display("[TB] collision warning at %0t addr %0d", $time, adA);
`endif
    endtask

    task automatic checkAll();
        checkOutput("P.DOA", busP.DOA, expDo[0][0]);
        checkOutput("P.DOB", busP.DOB, expDo[0][1]);
        checkOutput("Q.DOA", busQ.DOA, expDo[1][0]);
        checkOutput("Q.DOB", busQ.DOB, expDo[1][1]);
        checkOutput("P.COLL", busP.COLLISION, expColl);
        checkOutput("Q.COLL", busQ.COLLISION, expColl);
        checkOutput("P.BUSY", busP.INIT_BUSY, 1'b0);
        checkOutput("Q.BUSY", busQ.INIT_BUSY, 1'b0);
    endtask

    task automatic applyStimulus(input logic cea, input logic ceb, input logic ocea,
                                 input logic oceb, input logic wea, input logic web,
                                 input logic [AW-1:0] ada, input logic [AW-1:0] adb,
                                 input logic [DW-1:0] dia, input logic [DW-1:0] dib);
        ceA = cea; ceB = ceb; oceA = ocea; oceB = oceb; weA = wea; weB = web;
        adA = ada; adB = adb; diA = dia; diB = dib;
        @(posedge CLKA);
        modelEdge();
        #1;
        checkAll();
    endtask

    task automatic doReset();
        RESETB = 1'b1;
        ceA = 0; ceB = 0; oceA = 0; oceB = 0; weA = 0; weB = 0;
        @(posedge CLKA);
        #1;
        checkOutput("rst.P.DOA", busP.DOA, 8'h00);
        checkOutput("rst.P.DOB", busP.DOB, 8'h00);
        checkOutput("rst.Q.DOA", busQ.DOA, 8'h00);
        checkOutput("rst.Q.DOB", busQ.DOB, 8'h00);
        checkOutput("rst.P.BUSY", busP.INIT_BUSY, 1'b1);
        checkOutput("rst.Q.BUSY", busQ.INIT_BUSY, 1'b1);
        checkOutput("rst.P.COLL", busP.COLLISION, 1'b0);
        RESETB = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                expDo[d][p] = '0;
                stage[d][p] = '0;
            end
        expColl = 1'b0;
    endtask

    // Hammer both ports with writes while the sweep runs; all must be ignored.
    task automatic sweepEdges(input int n, input logic expBusy);
        for (int i = 0; i < n; i++) begin
            ceA = 1; ceB = 1; oceA = 1; oceB = 1; weA = 1; weB = 1;
            adA = AW'($urandom); adB = AW'($urandom);
            diA = DW'($urandom) | 8'h01; diB = DW'($urandom) | 8'h01;
            @(posedge CLKA);
            #1;
            checkOutput("sweep.P.BUSY", busP.INIT_BUSY, expBusy);
            checkOutput("sweep.Q.BUSY", busQ.INIT_BUSY, expBusy);
            checkOutput("sweep.P.DOA", busP.DOA, 8'h00);
            checkOutput("sweep.Q.DOB", busQ.DOB, 8'h00);
        end
        ceA = 0; ceB = 0; oceA = 0; oceB = 0; weA = 0; weB = 0;
    endtask

    initial begin
        doReset();
        sweepEdges(8, 1'b1);
        doReset();
        sweepEdges(16, 1'b1);
        sweepEdges(1, 1'b0);
        for (int a = 0; a < DEPTH; a++) refMem[a] = '0;

        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(1, 1, 1, 1, 0, 0, AW'(a), AW'(DEPTH - 1 - a), 8'h00, 8'h00);
            checkOutput("clearRead", busP.DOA, 8'h00);
        end

        applyStimulus(1, 0, 1, 0, 1, 0, 4'd3, 4'd0, 8'h11, 8'h00);
        applyStimulus(1, 0, 1, 0, 0, 0, 4'd3, 4'd0, 8'h00, 8'h00);
        checkOutput("readBack11", busP.DOA, 8'h11);
        applyStimulus(1, 0, 1, 0, 1, 0, 4'd3, 4'd0, 8'h22, 8'h00);
        checkOutput("writeThrough", busP.DOA, 8'h22);
        checkOutput("normalHold", busQ.DOA, 8'h11);
        applyStimulus(0, 1, 0, 1, 0, 1, 4'd0, 4'd3, 8'h00, 8'h33);
        checkOutput("readBeforeWrite", busP.DOB, 8'h22);
        applyStimulus(1, 0, 1, 0, 0, 0, 4'd3, 4'd0, 8'h00, 8'h00);
        checkOutput("readBack33", busP.DOA, 8'h33);

        applyStimulus(1, 0, 0, 0, 1, 0, 4'd5, 4'd0, 8'hA5, 8'h00);
        applyStimulus(0, 1, 0, 0, 0, 0, 4'd0, 4'd5, 8'h00, 8'h00);
        checkOutput("pipeNotYet", busQ.DOB == 8'hA5, 1'b0);
        applyStimulus(0, 0, 0, 1, 0, 0, 4'd0, 4'd0, 8'h00, 8'h00);
        checkOutput("pipeValid", busQ.DOB, 8'hA5);

        applyStimulus(1, 1, 0, 0, 1, 1, 4'd9, 4'd9, 8'h0F, 8'hF0);
        checkOutput("dblWrCollision", busP.COLLISION, COLL_EXP);
        applyStimulus(0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 8'h00, 8'h00);
        checkOutput("collisionDrop", busP.COLLISION, 1'b0);
        applyStimulus(1, 1, 1, 1, 0, 0, 4'd9, 4'd9, 8'h00, 8'h00);
        checkOutput("dblWrAWins", busP.DOA, 8'h0F);

        applyStimulus(1, 0, 0, 0, 1, 0, 4'd2, 4'd0, 8'h33, 8'h00);
        applyStimulus(1, 1, 1, 1, 1, 0, 4'd2, 4'd2, 8'h44, 8'h00);
        checkOutput("rwCollOld", busP.DOB, 8'h33);
        checkOutput("rwCollFlag", busQ.COLLISION, COLL_EXP);
        applyStimulus(0, 1, 0, 1, 0, 0, 4'd0, 4'd2, 8'h00, 8'h00);
        checkOutput("rwCollNew", busP.DOB, 8'h44);

        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] ra, rb;
            ra = (i % 2 == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            rb = (i % 3 == 0) ? ra : AW'($urandom_range(0, 3));
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom), ra, rb,
                          DW'($urandom), DW'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
